// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the Dijkstra engine memory arbiter.
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

package dijkstra_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Requester indices: edge-cache line fills and distance/prev writeback.
    localparam logic PORT_EDGE = 1'b0;
    localparam logic PORT_WB   = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side handshake bundle around the memory arbiter.
interface mem_arbiter_if #(
    parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
);
    logic                   p0_req;
    logic                   p0_write;
    logic [MADDR_WIDTH-1:0] p0_addr;
    logic [MDATA_WIDTH-1:0] p0_wdata;
    logic                   p0_done;
    logic [MDATA_WIDTH-1:0] p0_rdata;

    logic                   p1_req;
    logic                   p1_write;
    logic [MADDR_WIDTH-1:0] p1_addr;
    logic [MDATA_WIDTH-1:0] p1_wdata;
    logic                   p1_done;
    logic [MDATA_WIDTH-1:0] p1_rdata;

    logic                   mem_read_enable;
    logic                   mem_write_enable;
    logic [MADDR_WIDTH-1:0] mem_addr;
    logic [MDATA_WIDTH-1:0] mem_write_data;
    logic                   mem_read_ready;
    logic                   mem_write_ready;
    logic [MDATA_WIDTH-1:0] mem_read_data;

    // Arbiter side: serves both requesters and drives the memory port.
    modport master (
        input  p0_req, p0_write, p0_addr, p0_wdata,
        output p0_done, p0_rdata,
        input  p1_req, p1_write, p1_addr, p1_wdata,
        output p1_done, p1_rdata,
        output mem_read_enable, mem_write_enable, mem_addr, mem_write_data,
        input  mem_read_ready, mem_write_ready, mem_read_data
    );

    // Environment side: requesters and the memory itself.
    modport slave (
        output p0_req, p0_write, p0_addr, p0_wdata,
        input  p0_done, p0_rdata,
        output p1_req, p1_write, p1_addr, p1_wdata,
        input  p1_done, p1_rdata,
        input  mem_read_enable, mem_write_enable, mem_addr, mem_write_data,
        output mem_read_ready, mem_write_ready, mem_read_data
    );
endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant with a last-grant pointer.
// The pointer resets to the writeback port so the edge port wins the first collision.
module rr_arbiter2
    import dijkstra_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_strobe,
    output logic       grant_valid,
    output logic       grant_idx
);
    logic last_q;
    logic last_d;

    // Grant decode: a lone requester wins, a collision goes to the port not served last.
    always_comb begin
        grant_valid = |req;
        grant_idx   = PORT_EDGE;
        case (req)
            2'b01:   grant_idx = PORT_EDGE;
            2'b10:   grant_idx = PORT_WB;
            2'b11:   grant_idx = ~last_q;
            default: grant_idx = PORT_EDGE;
        endcase
    end

    // Pointer follows every grant that is actually taken.
    always_comb begin
        last_d = last_q;
        if (grant_strobe) begin
            last_d = grant_idx;
        end
    end

    // Last-grant pointer register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= PORT_WB;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares the single external memory port between the edge cache (port 0)
// and result writeback (port 1), one transaction at a time.
module mem_arbiter
    import dijkstra_pkg::*;
#(
    parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.master bus,
    output logic          busy
);
    arb_state_t             state_q, state_d;
    logic                   gnt_q, gnt_d;
    logic                   wr_q, wr_d;
    logic [MADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MDATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MDATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [MDATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic grant_valid;
    logic grant_idx;
    logic grant_strobe;

    // A grant is only taken from IDLE; requests elsewhere are ignored.
    assign grant_strobe = (state_q == IDLE) && grant_valid;

    rr_arbiter2 u_rr (
        .clock        (clock),
        .reset        (reset),
        .req          ({bus.p1_req, bus.p0_req}),
        .grant_strobe (grant_strobe),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx)
    );

    // Next-state and latch logic: capture the granted request, wait for the matching ready.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    gnt_d   = grant_idx;
                    wr_d    = grant_idx ? bus.p1_write : bus.p0_write;
                    addr_d  = grant_idx ? bus.p1_addr  : bus.p0_addr;
                    wdata_d = grant_idx ? bus.p1_wdata : bus.p0_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!wr_q && bus.mem_read_ready) begin
                    if (gnt_q == PORT_EDGE) begin
                        rdata0_d = bus.mem_read_data;
                    end else begin
                        rdata1_d = bus.mem_read_data;
                    end
                    state_d = RESP;
                end else if (wr_q && bus.mem_write_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-transaction registers; reset aborts any access in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            gnt_q    <= PORT_EDGE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        bus.mem_read_enable  = (state_q == ACCESS) && !wr_q;
        bus.mem_write_enable = (state_q == ACCESS) && wr_q;
        bus.mem_addr         = addr_q;
        bus.mem_write_data   = wdata_q;
        bus.p0_done          = (state_q == RESP) && (gnt_q == PORT_EDGE);
        bus.p1_done          = (state_q == RESP) && (gnt_q == PORT_WB);
        bus.p0_rdata         = rdata0_q;
        bus.p1_rdata         = rdata1_q;
        busy                 = (state_q != IDLE);
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;
    logic clock;
    logic reset;
    logic busy;
    int   errors;
    int   checks;

    mem_arbiter_if #(.MADDR_WIDTH(16), .MDATA_WIDTH(32)) bus ();

    mem_arbiter #(.MADDR_WIDTH(16), .MDATA_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then settled away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.p0_req = 0; bus.p0_write = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 0; bus.p1_write = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
        bus.mem_read_ready = 0; bus.mem_write_ready = 0; bus.mem_read_data = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        errors = 0;
        checks = 0;
        clear_inputs();
        do_reset();

        // Reset state
        check("rst_rd_en", bus.mem_read_enable, 0);
        check("rst_wr_en", bus.mem_write_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_p0_done", bus.p0_done, 0);
        check("rst_p1_done", bus.p1_done, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_write_data, 0);
        check("rst_p0_rdata", bus.p0_rdata, 0);
        check("rst_p1_rdata", bus.p1_rdata, 0);

        // 1: p0 read, ready on third ACCESS cycle
        bus.p0_req = 1; bus.p0_write = 0; bus.p0_addr = 16'h0040;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t1_rd_en", bus.mem_read_enable, 1);
            check("t1_addr", bus.mem_addr, 16'h0040);
            check("t1_busy", busy, 1);
            check("t1_p0_done_early", bus.p0_done, 0);
        end
        bus.mem_read_ready = 1; bus.mem_read_data = 32'hDEADBEEF;
        tick();
        check("t1_rd_en_off", bus.mem_read_enable, 0);
        check("t1_p0_done", bus.p0_done, 1);
        check("t1_p0_rdata", bus.p0_rdata, 32'hDEADBEEF);
        check("t1_p1_done", bus.p1_done, 0);
        bus.mem_read_ready = 0; bus.p0_req = 0;
        tick();
        check("t1_done_pulse", bus.p0_done, 0);
        check("t1_idle", busy, 0);

        // 2: p1 write, ready in first ACCESS cycle
        bus.p1_req = 1; bus.p1_write = 1; bus.p1_addr = 16'h0100; bus.p1_wdata = 32'h12345678;
        tick();
        check("t2_wr_en", bus.mem_write_enable, 1);
        check("t2_rd_en", bus.mem_read_enable, 0);
        check("t2_addr", bus.mem_addr, 16'h0100);
        check("t2_wdata", bus.mem_write_data, 32'h12345678);
        bus.mem_write_ready = 1;
        tick();
        check("t2_wr_en_off", bus.mem_write_enable, 0);
        check("t2_p1_done", bus.p1_done, 1);
        check("t2_p0_done", bus.p0_done, 0);
        check("t2_p1_rdata", bus.p1_rdata, 0);
        bus.mem_write_ready = 0; bus.p1_req = 0;
        tick();
        check("t2_idle", busy, 0);

        // 3: collision from the first cycle after reset, alternating grants
        clear_inputs();
        do_reset();
        bus.p0_req = 1; bus.p0_addr = 16'h0200;
        bus.p1_req = 1; bus.p1_addr = 16'h0300;
        for (int i = 0; i < 8; i++) begin
            logic e;
            logic [31:0] d;
            e = i[0];
            d = 32'hA0000000 + 32'(i);
            tick();
            check("t3_rd_en", bus.mem_read_enable, 1);
            check("t3_grant_addr", bus.mem_addr, e ? 16'h0300 : 16'h0200);
            bus.mem_read_ready = 1; bus.mem_read_data = d;
            tick();
            check("t3_p0_done", bus.p0_done, (e == 1'b0));
            check("t3_p1_done", bus.p1_done, (e == 1'b1));
            check("t3_rdata", e ? bus.p1_rdata : bus.p0_rdata, d);
            bus.mem_read_ready = 0;
            if (i >= 6) begin
                if (e) bus.p1_req = 0;
                else   bus.p0_req = 0;
            end
            tick();
        end
        check("t3_idle", busy, 0);

        // 4: reset in the middle of a pending read
        bus.p0_req = 1; bus.p0_write = 0; bus.p0_addr = 16'h0055;
        tick();
        check("t4_rd_en", bus.mem_read_enable, 1);
        tick();
        reset = 1;
        #1;
        check("t4_rst_rd_en", bus.mem_read_enable, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_addr", bus.mem_addr, 0);
        check("t4_rst_p0_rdata", bus.p0_rdata, 0);
        bus.p0_req = 0;
        tick();
        reset = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t4_no_done", bus.p0_done, 0);
            check("t4_no_busy", busy, 0);
        end
        bus.p0_req = 1; bus.p0_addr = 16'h0056;
        tick();
        check("t4_re_rd_en", bus.mem_read_enable, 1);
        check("t4_re_addr", bus.mem_addr, 16'h0056);
        bus.mem_read_ready = 1; bus.mem_read_data = 32'h0BADF00D;
        tick();
        check("t4_re_done", bus.p0_done, 1);
        check("t4_re_rdata", bus.p0_rdata, 32'h0BADF00D);
        bus.mem_read_ready = 0; bus.p0_req = 0;
        tick();

        // 5: stray readies in IDLE and a non-matching ready during a read
        bus.mem_read_ready = 1; bus.mem_write_ready = 1;
        tick();
        check("t5_idle_busy", busy, 0);
        check("t5_idle_done", bus.p0_done, 0);
        bus.mem_read_ready = 0; bus.mem_write_ready = 0;
        bus.p0_req = 1; bus.p0_addr = 16'h0077;
        tick();
        check("t5_rd_en", bus.mem_read_enable, 1);
        bus.mem_write_ready = 1;
        tick();
        check("t5_stray_rd_en", bus.mem_read_enable, 1);
        check("t5_stray_done", bus.p0_done, 0);
        bus.mem_read_ready = 1; bus.mem_read_data = 32'h5A5A5A5A;
        tick();
        check("t5_done", bus.p0_done, 1);
        check("t5_rdata", bus.p0_rdata, 32'h5A5A5A5A);
        bus.mem_read_ready = 0; bus.mem_write_ready = 0; bus.p0_req = 0;
        tick();

        // 6: p0 streaming, p1 injects one write mid-stream
        bus.p0_req = 1; bus.p0_write = 0; bus.p0_addr = 16'h0600;
        tick();
        check("t6_a_addr", bus.mem_addr, 16'h0600);
        bus.p1_req = 1; bus.p1_write = 1; bus.p1_addr = 16'h0700; bus.p1_wdata = 32'hCAFEF00D;
        bus.mem_read_ready = 1; bus.mem_read_data = 32'h00000011;
        tick();
        check("t6_a_done", bus.p0_done, 1);
        bus.mem_read_ready = 0;
        tick();
        tick();
        check("t6_b_wr_en", bus.mem_write_enable, 1);
        check("t6_b_addr", bus.mem_addr, 16'h0700);
        check("t6_b_wdata", bus.mem_write_data, 32'hCAFEF00D);
        bus.mem_write_ready = 1;
        tick();
        check("t6_b_done", bus.p1_done, 1);
        bus.mem_write_ready = 0; bus.p1_req = 0;
        tick();
        tick();
        check("t6_c_rd_en", bus.mem_read_enable, 1);
        check("t6_c_addr", bus.mem_addr, 16'h0600);
        bus.mem_read_ready = 1; bus.mem_read_data = 32'h00000022;
        tick();
        check("t6_c_done", bus.p0_done, 1);
        check("t6_c_rdata", bus.p0_rdata, 32'h00000022);
        bus.mem_read_ready = 0; bus.p0_req = 0;
        tick();
        check("t6_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
